// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit with a three-state IDLE/CALC/DONE sequencer
//
// Purpose:
//   Executes the eight RV32M operations (mul, mulh, mulhsu, mulhu, div, divu,
//   rem, remu). Multiply is shift-add and divide is restoring, both running on
//   operand magnitudes with one iteration per cycle over 32 cycles. A single
//   two's-complement correction then restores the sign. Divide-by-zero and
//   signed overflow skip CALC and finish one cycle after start is sampled.
//
// Build option:
//   MULDIV_FAST_MUL_EN - multiplies use a single-cycle 33x33 signed product
//                        registered in a one-cycle CALC. Divide is unchanged.
//
// Ports:
//   clk      in   1  clock, all state on the rising edge
//   reset    in   1  asynchronous active-high reset
//   start    in   1  operation request, sampled only in IDLE
//   kill     in   1  synchronous abort, returns to IDLE, has priority over start
//   alu_ctrl in   5  operation code (10010..11001 are M-ops)
//   src_a    in  32  rs1 operand
//   src_b    in  32  rs2 operand
//   busy     out  1  high in CALC and DONE
//   done     out  1  one-cycle result-valid pulse
//   result   out 32  result, held until the next completion
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic [4:0]  alu_ctrl,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Internal operation index: alu_ctrl[2:0] - 2 maps the eight codes onto 0..7.
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  r_op;
  logic [31:0] r_a_mag;
  logic [31:0] r_b_mag;
  logic        r_neg;       // negate product / quotient at the end
  logic        r_rem_neg;   // negate remainder (follows dividend sign)
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_result;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // ---------------------------------------------------------------------------
  logic        w_is_m;
  logic [2:0]  w_op;
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_div_zero;
  logic        w_ovf;
  logic        w_bypass;
  logic        w_accept;
  logic [31:0] w_special_res;

  assign w_is_m     = (alu_ctrl >= 5'b10010) && (alu_ctrl <= 5'b11001);
  assign w_op       = alu_ctrl[2:0] - 3'd2;

  // mul's low word is independent of signedness, so it shares the signed path.
  assign w_a_signed = (w_op == OP_MUL) || (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                      (w_op == OP_DIV) || (w_op == OP_REM);
  assign w_b_signed = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                      (w_op == OP_DIV) || (w_op == OP_REM);

  assign w_a_neg    = w_a_signed & src_a[31];
  assign w_b_neg    = w_b_signed & src_b[31];
  assign w_a_mag    = w_a_neg ? (~src_a + 32'd1) : src_a;
  assign w_b_mag    = w_b_neg ? (~src_b + 32'd1) : src_b;

  assign w_div_zero = w_op[2] && (src_b == 32'd0);
  assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign w_bypass   = w_div_zero || w_ovf;
  assign w_accept   = start && !kill && w_is_m;

  always_comb begin
    w_special_res = 32'd0;
    if (w_div_zero) begin
      // w_op[1] clear selects a quotient op (div/divu), set selects rem/remu.
      w_special_res = w_op[1] ? src_a : 32'hFFFF_FFFF;
    end else if (w_ovf) begin
      w_special_res = (w_op == OP_DIV) ? 32'h8000_0000 : 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // Multiply: r_acc = {partial_hi, remaining multiplier bits}. Add the
  // multiplicand into the high half when the multiplier LSB is set, then shift
  // the 65-bit {carry, acc} right by one.
  logic [63:0] w_mul_step;

`ifdef MULDIV_FAST_MUL_EN
  // Zero-extended magnitudes keep the signed product non-negative, so the
  // shared sign correction below applies unchanged.
  logic signed [32:0] w_fast_a;
  logic signed [32:0] w_fast_b;
  logic signed [63:0] w_fast_prod;

  assign w_fast_a    = $signed({1'b0, r_a_mag});
  assign w_fast_b    = $signed({1'b0, r_b_mag});
  assign w_fast_prod = 64'(w_fast_a) * 64'(w_fast_b);
  assign w_mul_step  = w_fast_prod;
`else
  logic [32:0] w_mul_sum;

  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a_mag} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};
`endif

  // Restoring divide: r_acc = {partial_remainder, remaining dividend/quotient}.
  // The shifted remainder needs 33 bits; when it is >= divisor the true
  // difference fits in 32 bits, so a modulo-2^32 subtract suffices.
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_div_diff;
  logic [63:0] w_div_step;

  assign w_rem_sh   = r_acc[63:31];
  assign w_ge       = (w_rem_sh >= {1'b0, r_b_mag});
  assign w_div_diff = w_rem_sh[31:0] - r_b_mag;
  assign w_div_step = {(w_ge ? w_div_diff : w_rem_sh[31:0]), r_acc[30:0], w_ge};

  logic [63:0] w_acc_next;
  logic        w_calc_last;

  assign w_acc_next = r_op[2] ? w_div_step : w_mul_step;

`ifdef MULDIV_FAST_MUL_EN
  assign w_calc_last = !r_op[2] || (r_cnt == 5'd31);
`else
  assign w_calc_last = (r_cnt == 5'd31);
`endif

  // Final result from the value the last iteration produces.
  logic [63:0] w_mul_signed;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_final_res;

  assign w_mul_signed = r_neg ? (~w_acc_next + 64'd1) : w_acc_next;
  assign w_quot       = w_acc_next[31:0];
  assign w_rem        = w_acc_next[63:32];

  always_comb begin
    w_final_res = 32'd0;
    case (r_op)
      OP_MUL:                      w_final_res = w_mul_signed[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final_res = w_mul_signed[63:32];
      OP_DIV, OP_DIVU:             w_final_res = r_neg ? (~w_quot + 32'd1) : w_quot;
      default:                     w_final_res = r_rem_neg ? (~w_rem + 32'd1) : w_rem;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = w_bypass ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_calc_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (kill) begin
      w_state_next = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand latch, iteration registers and result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= 3'd0;
      r_a_mag   <= 32'd0;
      r_b_mag   <= 32'd0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_cnt     <= 5'd0;
      r_acc     <= 64'd0;
      r_result  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= w_op;
            r_a_mag   <= w_a_mag;
            r_b_mag   <= w_b_mag;
            r_neg     <= w_a_neg ^ w_b_neg;
            r_rem_neg <= w_a_neg;
            r_cnt     <= 5'd0;
            // Dividend shifts out of the low half for divide; multiplier
            // bits shift out of the low half for multiply.
            r_acc     <= {32'd0, (w_op[2] ? w_a_mag : w_b_mag)};
            if (w_bypass) begin
              r_result <= w_special_res;
            end
          end
        end
        S_CALC: begin
          if (!kill) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 5'd1;
            if (w_calc_last) begin
              r_result <= w_final_res;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        kill;
  logic [4:0]  alu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [4:0] C_MUL    = 5'b10010;
  localparam logic [4:0] C_MULH   = 5'b10011;
  localparam logic [4:0] C_MULHSU = 5'b10100;
  localparam logic [4:0] C_MULHU  = 5'b10101;
  localparam logic [4:0] C_DIV    = 5'b10110;
  localparam logic [4:0] C_DIVU   = 5'b10111;
  localparam logic [4:0] C_REM    = 5'b11000;
  localparam logic [4:0] C_REMU   = 5'b11001;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .kill     (kill),
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference results straight from the RV32M arithmetic definitions.
  function automatic logic [31:0] model_res(input logic [4:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (code)
      C_MUL:    begin p = sa * sb; return p[31:0]; end
      C_MULH:   begin p = sa * sb; return p[63:32]; end
      C_MULHSU: begin p = sa * ub; return p[63:32]; end
      C_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      C_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      C_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      C_REM: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      C_REMU:   return (b == 0) ? a : a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] code, input logic [31:0] a,
                                   input logic [31:0] b);
    if (code inside {C_DIV, C_DIVU, C_REM, C_REMU}) begin
      if (b == 0) return 1;
      if ((code == C_DIV || code == C_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return 1;
      return 33;
    end
    return MUL_LAT;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    alu_ctrl = c;
    src_a    = a;
    src_b    = b;
  endtask

  // Called with start already driven; the next rising edge samples it.
  task automatic finish_op(input string tag, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    bit busy_bad;
    step();
    start    = 1'b0;
    alu_ctrl = 5'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
    cyc      = 1;
    busy_bad = 1'b0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      step();
      cyc++;
    end
    if (busy !== 1'b1) busy_bad = 1'b1;
    check_eq({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, ".result"}, {32'd0, result}, {32'd0, exp_res});
    check_eq({tag, ".busy"}, {63'd0, busy_bad}, 64'd0);
    step();
    check_eq({tag, ".idle_after"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    @(negedge clk);
    issue(c, a, b);
    finish_op(tag, exp_res, model_lat(c, a, b));
  endtask

  task automatic watch_quiet(input int n, input string tag);
    bit bad;
    bad = 1'b0;
    repeat (n) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    check_eq(tag, {63'd0, bad}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 100));
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] codes [8];

  initial begin
    int cyc;
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;

    codes = '{C_MUL, C_MULH, C_MULHSU, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU};
    reset = 1'b1; start = 1'b0; kill = 1'b0;
    alu_ctrl = 5'd0; src_a = 32'd0; src_b = 32'd0;

    repeat (3) step();
    check_eq("reset.busy", {63'd0, busy}, 64'd0);
    check_eq("reset.done", {63'd0, done}, 64'd0);
    check_eq("reset.result", {32'd0, result}, 64'd0);

    // First start sampled on the first edge after release.
    @(negedge clk);
    reset = 1'b0;
    issue(C_MUL, 32'd7, 32'hFFFF_FFFD);
    finish_op("mul_7x-3", 32'hFFFF_FFEB, MUL_LAT);

    run_op("mulhu_ff", C_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mulh_ff",  C_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulhsu_ff", C_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_-7_2",  C_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem_-7_2",  C_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu_-7_2", C_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    run_op("div_by0",   C_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_by0",  C_REMU, 32'd5, 32'd0, 32'd5);
    run_op("div_ovf",   C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",   C_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    for (int i = 0; i < 60; i++) begin
      c = codes[$urandom_range(0, 7)];
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rand%0d_op%b_%h_%h", i, c, a, b), c, a, b, model_res(c, a, b));
    end

    // Known result in place before the no-op tests.
    run_op("div_100_3", C_DIV, 32'd100, 32'd3, 32'd33);

    // Non-M codes held on start: nothing happens, result held.
    @(negedge clk);
    issue(5'b00000, 32'd9, 32'd9);
    watch_quiet(40, "nonm_00000.quiet");
    alu_ctrl = 5'b10001;
    watch_quiet(5, "nonm_10001.quiet");
    alu_ctrl = 5'b11010;
    watch_quiet(5, "nonm_11010.quiet");
    start = 1'b0;
    check_eq("nonm.result_held", {32'd0, result}, 64'd33);

    // kill beats start in IDLE.
    @(negedge clk);
    kill = 1'b1;
    issue(C_MUL, 32'd3, 32'd3);
    watch_quiet(5, "kill_start.quiet");
    kill = 1'b0; start = 1'b0;

    // New request at cycle 5 of a running divide is ignored.
    @(negedge clk);
    issue(C_DIV, 32'd100, 32'd3);
    step(); start = 1'b0;
    repeat (4) step();
    issue(C_MUL, 32'd9, 32'd9);
    step(); start = 1'b0;
    cyc = 6;
    while (done !== 1'b1 && cyc < 60) begin step(); cyc++; end
    check_eq("restart.latency", 64'(cyc), 64'd33);
    check_eq("restart.result", {32'd0, result}, 64'd33);
    step();

    // kill at cycle 10: IDLE at 11, no done, result kept.
    @(negedge clk);
    issue(C_DIV, 32'd100, 32'd7);
    step(); start = 1'b0;
    repeat (9) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    check_eq("kill.idle", {62'd0, busy, done}, 64'd0);
    watch_quiet(40, "kill.quiet");
    check_eq("kill.result_held", {32'd0, result}, 64'd33);

    // Asynchronous reset at cycle 12: outputs clear before any edge.
    @(negedge clk);
    issue(C_DIV, 32'd100, 32'd3);
    step(); start = 1'b0;
    repeat (11) step();
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid.outputs", {30'd0, busy, done, result}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    watch_quiet(40, "rst_mid.quiet");
    check_eq("rst_mid.result", {32'd0, result}, 64'd0);

    run_op("post_reset_remu", C_REMU, 32'd100, 32'd7, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
